// File: rtl/imu_spi_seq.sv
// rtl/imu_spi_seq.sv - inertial sensor SPI transaction sequencer
//
// Sole requester of the SPI monarch attached to the inertial sensor. Waits out
// a power-up interval, writes three configuration registers, then services the
// sensor data-ready line by reading the yaw-rate low/high bytes and presenting
// a registered 16-bit yaw rate with a one-cycle valid pulse.
//
// Ports:
//   clk        system clock (only clock)
//   rst        synchronous active-high reset
//   INT        sensor data-ready, asynchronous (synchronised here)
//   done       SPI monarch transaction complete (level, cleared by wrt)
//   rd_data    SPI monarch read data, [7:0] meaningful
//   wrt        one-cycle pulse starting an SPI transaction
//   cmd        command word, valid while wrt is high and held until next issue
//   yaw_rt     signed yaw rate {high byte, low byte}
//   vld        one-cycle pulse when yaw_rt updates
//   init_done  configuration complete, sticky until reset
module imu_spi_seq #(
    parameter int STARTUP_BITS = 16
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        INT,
    input  logic        done,
    input  logic [15:0] rd_data,
    output logic        wrt,
    output logic [15:0] cmd,
    output logic [15:0] yaw_rt,
    output logic        vld,
    output logic        init_done
);

    localparam logic [15:0] CFG0  = 16'h0D02;
    localparam logic [15:0] CFG1  = 16'h1160;
    localparam logic [15:0] CFG2  = 16'h1440;
    localparam logic [15:0] RD_YL = 16'hA600;
    localparam logic [15:0] RD_YH = 16'hA700;

    typedef enum logic [2:0] {
        PWRUP  = 3'd0,
        W_CFG0 = 3'd1,
        W_CFG1 = 3'd2,
        W_CFG2 = 3'd3,
        IDLE   = 3'd4,
        W_YL   = 3'd5,
        W_YH   = 3'd6
    } state_t;

    state_t                  state;
    state_t                  next_state;
    logic [STARTUP_BITS-1:0] timer;
    logic                    INT_ff1;
    logic                    INT_ff2;
    logic                    armed;
    logic [7:0]              yl;

    logic                    timer_sat;
    logic                    in_wait;
    logic                    advance;
    logic                    wrt_nxt;
    logic [15:0]             cmd_nxt;
    logic                    load_yl;
    logic                    load_yaw;
    logic                    set_init;
    logic                    unused_rd_hi;

    assign unused_rd_hi = ^rd_data[15:8];

    assign timer_sat = &timer;
    assign in_wait   = (state == W_CFG0) || (state == W_CFG1) || (state == W_CFG2) ||
                       (state == W_YL)   || (state == W_YH);
    // armed is cleared on every issue and only set once done has been seen low
    // inside the wait state, so a done left high from the previous transaction
    // can never complete the new one.
    assign advance   = in_wait && done && armed;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= PWRUP;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic
    always_comb begin
        next_state = PWRUP;
        case (state)
            PWRUP:   next_state = timer_sat ? W_CFG0 : PWRUP;
            W_CFG0:  next_state = advance ? W_CFG1 : W_CFG0;
            W_CFG1:  next_state = advance ? W_CFG2 : W_CFG1;
            W_CFG2:  next_state = advance ? IDLE : W_CFG2;
            IDLE:    next_state = INT_ff2 ? W_YL : IDLE;
            W_YL:    next_state = advance ? W_YH : W_YL;
            W_YH:    next_state = advance ? IDLE : W_YH;
            default: next_state = PWRUP;
        endcase
    end

    // Output decode: issue on entry into a wait state, plus datapath strobes
    always_comb begin
        wrt_nxt  = 1'b0;
        cmd_nxt  = cmd;
        if (next_state != state) begin
            case (next_state)
                W_CFG0:  begin wrt_nxt = 1'b1; cmd_nxt = CFG0;  end
                W_CFG1:  begin wrt_nxt = 1'b1; cmd_nxt = CFG1;  end
                W_CFG2:  begin wrt_nxt = 1'b1; cmd_nxt = CFG2;  end
                W_YL:    begin wrt_nxt = 1'b1; cmd_nxt = RD_YL; end
                W_YH:    begin wrt_nxt = 1'b1; cmd_nxt = RD_YH; end
                default: ;
            endcase
        end
        load_yl  = (state == W_YL)   && advance;
        load_yaw = (state == W_YH)   && advance;
        set_init = (state == W_CFG2) && advance;
    end

    // Registered outputs, timer, synchroniser and datapath
    always_ff @(posedge clk) begin
        if (rst) begin
            INT_ff1   <= 1'b0;
            INT_ff2   <= 1'b0;
            timer     <= '0;
            armed     <= 1'b0;
            wrt       <= 1'b0;
            cmd       <= 16'h0000;
            yl        <= 8'h00;
            yaw_rt    <= 16'h0000;
            vld       <= 1'b0;
            init_done <= 1'b0;
        end else begin
            INT_ff1 <= INT;
            INT_ff2 <= INT_ff1;
            if (state == PWRUP) begin
                timer <= timer + {{(STARTUP_BITS-1){1'b0}}, 1'b1};
            end
            if (wrt_nxt) begin
                armed <= 1'b0;
            end else if (in_wait && !done) begin
                armed <= 1'b1;
            end
            wrt <= wrt_nxt;
            cmd <= cmd_nxt;
            if (load_yl) begin
                yl <= rd_data[7:0];
            end
            if (load_yaw) begin
                yaw_rt <= {rd_data[7:0], yl};
            end
            vld       <= load_yaw;
            init_done <= init_done | set_init;
        end
    end

endmodule

// File: tb/tb_imu_spi_seq.sv
// tb/tb_imu_spi_seq.sv - self-checking bench for imu_spi_seq
module tb_imu_spi_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        INT = 1'b0;
    logic        done = 1'b0;
    logic [15:0] rd_data = 16'h0000;
    logic        wrt;
    logic [15:0] cmd;
    logic [15:0] yaw_rt;
    logic        vld;
    logic        init_done;

    imu_spi_seq #(.STARTUP_BITS(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .INT       (INT),
        .done      (done),
        .rd_data   (rd_data),
        .wrt       (wrt),
        .cmd       (cmd),
        .yaw_rt    (yaw_rt),
        .vld       (vld),
        .init_done (init_done)
    );

    always #10 clk = ~clk;

    int          n_checks = 0;
    int          n_fail = 0;
    logic [15:0] exp_cmd_q[$];
    logic [15:0] exp_yaw_q[$];
    logic [7:0]  byte_q[$];
    int          wrt_count = 0;
    int          vld_count = 0;
    int          wrt_base = 0;
    bit          in_flight = 1'b0;
    int          stale_cycles = 0;
    int          serf_lat = 4;
    int          hold = 0;
    int          cnt = 0;
    bit          busy = 1'b0;
    logic [15:0] cur_cmd = 16'h0000;

    // SPI serf model plus scoreboard pop side, evaluated away from the rising edge
    always @(negedge clk) begin : serf_monitor
        logic [15:0] e;
        if (wrt) begin
            wrt_count++;
            n_checks++;
            if (in_flight) begin
                n_fail++;
                $display("FAIL wrt_overlap: wrt=1 cmd=%h while a transaction is in flight, required no wrt", cmd);
            end
            n_checks++;
            if (exp_cmd_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_wrt: cmd=%h, required no wrt", cmd);
            end else begin
                e = exp_cmd_q.pop_front();
                if (cmd !== e) begin
                    n_fail++;
                    $display("FAIL cmd_seq: got %h, required %h", cmd, e);
                end
            end
            in_flight = 1'b1;
            cur_cmd   = cmd;
            busy      = 1'b0;
            if (stale_cycles == 0) begin
                done = 1'b0;
                cnt  = serf_lat;
                busy = 1'b1;
            end else begin
                hold = stale_cycles;
            end
        end else if (hold > 0) begin
            hold--;
            if (hold == 0) begin
                done = 1'b0;
                cnt  = serf_lat;
                busy = 1'b1;
            end
        end else if (busy) begin
            cnt--;
            if (cnt == 0) begin
                busy      = 1'b0;
                done      = 1'b1;
                in_flight = 1'b0;
                if (cur_cmd[15]) begin
                    if (byte_q.size() > 0) rd_data = {8'h00, byte_q.pop_front()};
                    else rd_data = 16'h0000;
                end
            end
        end
        if (vld) begin
            vld_count++;
            n_checks++;
            if (exp_yaw_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_vld: yaw_rt=%h, required no vld", yaw_rt);
            end else begin
                e = exp_yaw_q.pop_front();
                if (yaw_rt !== e) begin
                    n_fail++;
                    $display("FAIL yaw_value: got %h, required %h", yaw_rt, e);
                end
            end
        end
    end

    task automatic step();
        @(negedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) step();
        n_checks++; if (wrt !== 1'b0)        begin n_fail++; $display("FAIL reset_wrt: got %b, required 0", wrt); end
        n_checks++; if (cmd !== 16'h0000)    begin n_fail++; $display("FAIL reset_cmd: got %h, required 0000", cmd); end
        n_checks++; if (yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL reset_yaw: got %h, required 0000", yaw_rt); end
        n_checks++; if (vld !== 1'b0)        begin n_fail++; $display("FAIL reset_vld: got %b, required 0", vld); end
        n_checks++; if (init_done !== 1'b0)  begin n_fail++; $display("FAIL reset_init_done: got %b, required 0", init_done); end
    endtask

    task automatic test_powerup();
        int cyc;
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1160);
        exp_cmd_q.push_back(16'h1440);
        wrt_base = wrt_count;
        rst = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            step();
            cyc++;
            if (wrt_count != wrt_base) break;
        end
        n_checks++;
        if (cyc != 16) begin
            n_fail++;
            $display("FAIL pwrup_wait: first wrt after %0d cycles, required 16", cyc);
        end
    endtask

    task automatic test_config();
        int cyc;
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 200) begin
            step();
            cyc++;
        end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL cfg_init_done: got %b, required 1", init_done); end
        n_checks++; if (wrt_count - wrt_base != 3) begin n_fail++; $display("FAIL cfg_wrt_count: got %0d, required 3", wrt_count - wrt_base); end
        n_checks++; if (in_flight) begin n_fail++; $display("FAIL cfg_init_early: init_done=1 with transaction in flight, required after third done"); end
        repeat (10) step();
        n_checks++; if (wrt_count - wrt_base != 3) begin n_fail++; $display("FAIL cfg_idle_wrt: got %0d wrt, required 3", wrt_count - wrt_base); end
        n_checks++; if (vld_count != 0) begin n_fail++; $display("FAIL cfg_vld: got %0d pulses, required 0", vld_count); end
        n_checks++; if (exp_cmd_q.size() != 0) begin n_fail++; $display("FAIL cfg_cmds_left: %0d not issued, required 0", exp_cmd_q.size()); end
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL cfg_init_sticky: got %b, required 1", init_done); end
    endtask

    task automatic test_read();
        int w0, v0, int_lat, cyc;
        exp_cmd_q.push_back(16'hA600);
        exp_cmd_q.push_back(16'hA700);
        byte_q.push_back(8'h34);
        byte_q.push_back(8'h12);
        exp_yaw_q.push_back(16'h1234);
        w0 = wrt_count;
        v0 = vld_count;
        INT = 1'b1;
        int_lat = 0;
        while (int_lat < 20) begin
            step();
            int_lat++;
            if (wrt_count != w0) break;
        end
        INT = 1'b0;
        n_checks++; if (int_lat != 3) begin n_fail++; $display("FAIL int_latency: got %0d cycles, required 3", int_lat); end
        cyc = 0;
        while (vld_count == v0 && cyc < 100) begin step(); cyc++; end
        repeat (10) step();
        n_checks++; if (vld_count - v0 != 1) begin n_fail++; $display("FAIL read_vld_count: got %0d, required 1", vld_count - v0); end
        n_checks++; if (yaw_rt !== 16'h1234) begin n_fail++; $display("FAIL read_yaw: got %h, required 1234", yaw_rt); end
        n_checks++; if (wrt_count - w0 != 2) begin n_fail++; $display("FAIL read_wrt_count: got %0d, required 2", wrt_count - w0); end
    endtask

    task automatic test_held_int();
        int w0, v0, cyc;
        exp_cmd_q.push_back(16'hA600);
        exp_cmd_q.push_back(16'hA700);
        exp_cmd_q.push_back(16'hA600);
        exp_cmd_q.push_back(16'hA700);
        byte_q.push_back(8'hFF);
        byte_q.push_back(8'h80);
        byte_q.push_back(8'h01);
        byte_q.push_back(8'h00);
        exp_yaw_q.push_back(16'h80FF);
        exp_yaw_q.push_back(16'h0001);
        w0 = wrt_count;
        v0 = vld_count;
        INT = 1'b1;
        cyc = 0;
        while (wrt_count - w0 < 3 && cyc < 200) begin step(); cyc++; end
        INT = 1'b0;
        cyc = 0;
        while (vld_count - v0 < 2 && cyc < 200) begin step(); cyc++; end
        repeat (10) step();
        n_checks++; if (vld_count - v0 != 2) begin n_fail++; $display("FAIL held_vld_count: got %0d, required 2", vld_count - v0); end
        n_checks++; if (yaw_rt !== 16'h0001) begin n_fail++; $display("FAIL held_yaw_last: got %h, required 0001", yaw_rt); end
        n_checks++; if (wrt_count - w0 != 4) begin n_fail++; $display("FAIL held_wrt_count: got %0d, required 4", wrt_count - w0); end
        n_checks++; if (exp_yaw_q.size() != 0) begin n_fail++; $display("FAIL held_yaw_left: %0d pending, required 0", exp_yaw_q.size()); end
    endtask

    task automatic test_stale_done();
        int w0, v0, cyc;
        stale_cycles = 2;
        exp_cmd_q.push_back(16'hA600);
        exp_cmd_q.push_back(16'hA700);
        byte_q.push_back(8'h56);
        byte_q.push_back(8'h78);
        exp_yaw_q.push_back(16'h7856);
        w0 = wrt_count;
        v0 = vld_count;
        INT = 1'b1;
        cyc = 0;
        while (wrt_count == w0 && cyc < 20) begin step(); cyc++; end
        INT = 1'b0;
        cyc = 0;
        while (vld_count == v0 && cyc < 200) begin step(); cyc++; end
        repeat (10) step();
        stale_cycles = 0;
        n_checks++; if (vld_count - v0 != 1) begin n_fail++; $display("FAIL stale_vld_count: got %0d, required 1", vld_count - v0); end
        n_checks++; if (yaw_rt !== 16'h7856) begin n_fail++; $display("FAIL stale_yaw: got %h, required 7856", yaw_rt); end
        n_checks++; if (wrt_count - w0 != 2) begin n_fail++; $display("FAIL stale_wrt_count: got %0d, required 2", wrt_count - w0); end
        n_checks++; if (exp_cmd_q.size() != 0) begin n_fail++; $display("FAIL stale_cmds_left: %0d not issued, required 0", exp_cmd_q.size()); end
    endtask

    task automatic test_mid_reset();
        int w0, v0, cyc;
        exp_cmd_q.push_back(16'hA600);
        exp_cmd_q.push_back(16'hA700);
        byte_q.push_back(8'h9A);
        byte_q.push_back(8'hBC);
        w0 = wrt_count;
        v0 = vld_count;
        INT = 1'b1;
        cyc = 0;
        while (wrt_count - w0 < 2 && cyc < 100) begin step(); cyc++; end
        INT = 1'b0;
        rst = 1'b1;
        step();
        n_checks++; if (wrt !== 1'b0)        begin n_fail++; $display("FAIL midrst_wrt: got %b, required 0", wrt); end
        n_checks++; if (cmd !== 16'h0000)    begin n_fail++; $display("FAIL midrst_cmd: got %h, required 0000", cmd); end
        n_checks++; if (yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL midrst_yaw: got %h, required 0000", yaw_rt); end
        n_checks++; if (vld !== 1'b0)        begin n_fail++; $display("FAIL midrst_vld: got %b, required 0", vld); end
        n_checks++; if (init_done !== 1'b0)  begin n_fail++; $display("FAIL midrst_init_done: got %b, required 0", init_done); end
        exp_cmd_q.push_back(16'h0D02);
        exp_cmd_q.push_back(16'h1160);
        exp_cmd_q.push_back(16'h1440);
        step();
        w0 = wrt_count;
        rst = 1'b0;
        cyc = 0;
        while (cyc < 100) begin
            step();
            cyc++;
            if (wrt_count != w0) break;
        end
        n_checks++; if (cyc != 16) begin n_fail++; $display("FAIL midrst_pwrup_wait: first wrt after %0d cycles, required 16", cyc); end
        cyc = 0;
        while (init_done !== 1'b1 && cyc < 200) begin step(); cyc++; end
        repeat (5) step();
        n_checks++; if (init_done !== 1'b1) begin n_fail++; $display("FAIL midrst_reinit: got %b, required 1", init_done); end
        n_checks++; if (wrt_count - w0 != 3) begin n_fail++; $display("FAIL midrst_cfg_count: got %0d, required 3", wrt_count - w0); end
        n_checks++; if (vld_count != v0) begin n_fail++; $display("FAIL midrst_vld: got %0d extra pulses, required 0", vld_count - v0); end
        n_checks++; if (yaw_rt !== 16'h0000) begin n_fail++; $display("FAIL midrst_yaw_after: got %h, required 0000", yaw_rt); end
        n_checks++; if (exp_cmd_q.size() != 0) begin n_fail++; $display("FAIL midrst_cmds_left: %0d not issued, required 0", exp_cmd_q.size()); end
    endtask

    initial begin
        test_reset();
        test_powerup();
        test_config();
        test_read();
        test_held_int();
        test_stale_done();
        test_mid_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1);
    end

endmodule
